quadc_sync_framer: RTL and testbench
====================================

# quadc_sync_framer

Sits directly downstream of the quad-ADC interface in the same clock domain. Takes the four 8-bit sample streams with their `valid` and `sync`, and packs them into one 32-bit word per valid cycle. Aligns a frame counter to the first external sync after a software arm, then emits a one-cycle `sync_out` at every frame boundary for the PFB/FFT chain. Also reports sync-alignment errors and per-channel clip counts for software monitoring.

## Interface
Parameters:
- `FRAME_LEN`, 2048: valid samples per frame; integer ≥ 2.
- `CNT_W`, 16: width of the saturating clip counters.

Ports:
- `user_clk`  in  1  sole clock (the ADC interface's adc0_clk domain).
- `reset_n`  in  1  asynchronous, active-low reset.
- `adc0_data`..`adc3_data`  in  8 each  signed two's-complement samples.
- `valid`  in  1  samples valid this cycle.
- `sync`  in  1  external sync level, sampled only when `valid`=1.
- `arm`  in  1  software arm; rising edge acts.
- `data_out`  out  32  {adc3,adc2,adc1,adc0}.
- `valid_out`  out  1  registered copy of `valid`.
- `sync_out`  out  1  frame-start pulse, qualified by `valid_out`.
- `frame_cnt`  out  32  count of `sync_out` pulses since arm; wraps.
- `armed`  out  1  state is ARMED.
- `running`  out  1  state is RUNNING.
- `sync_err`  out  1  sticky misaligned-sync flag.
- `clip0`..`clip3`  out  CNT_W each  saturating clip counts.

## Operation
- Edge detection:
  - `arm_q` registers `arm` every cycle; an arm edge is `arm & ~arm_q`.
  - `sync_q` updates only on valid cycles; a sync edge is `valid & sync & ~sync_q`.
- States: IDLE, ARMED, RUNNING.
- IDLE: arm edge → ARMED.
- ARMED:
  - On a sync edge → RUNNING.
  - That same sample carries `sync_out`=1, and the phase counter loads 1.
- RUNNING:
  - Each valid cycle, the phase counter (width clog2(FRAME_LEN)) increments and wraps FRAME_LEN−1 → 0.
  - A valid sample at phase 0 asserts `sync_out`.
- Sync edge in RUNNING at phase 0: normal, no error.
- Sync edge in RUNNING at phase ≠0:
  - Set `sync_err`.
  - Realign: this sample asserts `sync_out` and the phase loads 1.
- Arm edge in ARMED or RUNNING:
  - → ARMED.
  - Clears the phase counter, `frame_cnt`, `sync_err` and all clip counters.
  - A sync edge in the same cycle is ignored.
- Arm edge in IDLE coinciding with a sync edge: enter ARMED; the sync is ignored.
- `frame_cnt` increments on every `sync_out`=1 and wraps at 2^32.
- Clip counting:
  - A valid sample equal to 8'h7F or 8'h80 increments that channel's counter.
  - Counts in every state, saturating at 2^CNT_W−1.
- `data_out` and `valid_out` follow the input in every state. `sync_out` is only ever 1 in ARMED→RUNNING entry or in RUNNING.
- Invalid cycles: no counter, phase or sync_q change; `sync_out`=0.

## Timing
- Reset values: all outputs 0, state IDLE, `arm_q`/`sync_q` 0.
- Latency is 1 cycle from input to `data_out`/`valid_out`/`sync_out`, all registered together.
- `armed`/`running` reflect the state register. The transition is visible 1 cycle after the causing edge.
- `frame_cnt`, `sync_err` and `clipN` update in the cycle the corresponding `sync_out`/`data_out` appears.
- Reset asserted mid-frame: immediate return to reset values, with no pulse emitted.

## Test plan
1. **Reset.** Assert `reset_n`=0 mid-stream → all outputs 0 asynchronously. Release; with no arm → `sync_out` stays 0 and `data_out` tracks the inputs at 1-cycle latency.
2. **Arm and align.**
   - Stimulus: arm edge, then continuous valid, with a sync edge at sample 10; FRAME_LEN=8.
   - Response: `sync_out` on samples 10, 18, 26; `frame_cnt` = 1, 2, 3; `running`=1.
3. **Gapped valid.** Repeat scenario 2 with `valid` low every 3rd cycle → `sync_out` every 8 *valid* samples; phase does not advance on gaps.
4. **Misaligned sync.** Running with FRAME_LEN=8; sync edge at phase 5 → `sync_err`=1, `sync_out` on that sample, next pulse 8 valid samples later. A second aligned sync edge at phase 0 leaves `sync_err` at 1.
5. **Re-arm and simultaneity.** Arm edge while RUNNING, with a sync edge in the same cycle → ARMED. `frame_cnt`, `sync_err` and clips are 0, and there is no `sync_out`. The next sync edge starts a new frame.
6. **Clip saturation.** CNT_W=4; drive adc2=8'h80 for 20 valid cycles and adc1=8'h7E → `clip2`=15 and held, `clip1`=0.

Source files
------------

// File: rtl/quadc_sync_framer.sv
// Packs four ADC lanes into one 32-bit word, aligns a frame counter to external sync
// after a software arm, and keeps per-lane saturating clip counters.

module quadc_clip_lane #(
  parameter int CNT_W = 16
) (
  input  logic             user_clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [7:0]       sample,
  output logic [CNT_W-1:0] cnt
);
  logic hit;
  assign hit = en && (sample == 8'h7F || sample == 8'h80) && (cnt != '1);

  always_ff @(posedge user_clk or negedge reset_n)
    if (!reset_n)  cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (hit)  cnt <= cnt + 1'b1;
endmodule

module quadc_sync_framer #(
  parameter int FRAME_LEN = 2048,
  parameter int CNT_W     = 16
) (
  input  logic             user_clk,
  input  logic             reset_n,
  input  logic [7:0]       adc0_data,
  input  logic [7:0]       adc1_data,
  input  logic [7:0]       adc2_data,
  input  logic [7:0]       adc3_data,
  input  logic             valid,
  input  logic             sync,
  input  logic             arm,
  output logic [31:0]      data_out,
  output logic             valid_out,
  output logic             sync_out,
  output logic [31:0]      frame_cnt,
  output logic             armed,
  output logic             running,
  output logic             sync_err,
  output logic [CNT_W-1:0] clip0,
  output logic [CNT_W-1:0] clip1,
  output logic [CNT_W-1:0] clip2,
  output logic [CNT_W-1:0] clip3
);
  localparam int NUM_LANES = 4;
  localparam int PH_W      = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(FRAME_LEN - 1);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN} state_t;

  state_t                             state_q;
  logic                               arm_q, sync_q, valid_q, sync_out_q, err_q;
  logic [PH_W-1:0]                    phase_q;
  logic [31:0]                        frame_q;
  logic [NUM_LANES-1:0][7:0]          adc_bus, data_q;
  logic [NUM_LANES-1:0][CNT_W-1:0]    clip_q;
  logic                               arm_edge, sync_edge, clip_clr;

  assign adc_bus   = {adc3_data, adc2_data, adc1_data, adc0_data};
  assign arm_edge  = arm & ~arm_q;
  assign sync_edge = valid & sync & ~sync_q;
  // Re-arm wipes the monitoring counters; the first arm out of IDLE does not.
  assign clip_clr  = arm_edge && (state_q != S_IDLE);

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      arm_q      <= 1'b0;
      sync_q     <= 1'b0;
      valid_q    <= 1'b0;
      sync_out_q <= 1'b0;
      err_q      <= 1'b0;
      phase_q    <= '0;
      frame_q    <= '0;
      data_q     <= '0;
    end else begin
      arm_q      <= arm;
      if (valid) sync_q <= sync;
      data_q     <= adc_bus;
      valid_q    <= valid;
      sync_out_q <= 1'b0;
      case (state_q)
        S_IDLE: if (arm_edge) state_q <= S_ARMED;
        S_ARMED: begin
          if (arm_edge) begin
            phase_q <= '0;
            frame_q <= '0;
            err_q   <= 1'b0;
          end else if (sync_edge) begin
            state_q    <= S_RUN;
            sync_out_q <= 1'b1;
            phase_q    <= PH_ONE;
            frame_q    <= frame_q + 32'd1;
          end
        end
        S_RUN: begin
          if (arm_edge) begin
            state_q <= S_ARMED;
            phase_q <= '0;
            frame_q <= '0;
            err_q   <= 1'b0;
          end else if (valid) begin
            if (sync_edge && phase_q != '0) begin
              // Misaligned sync: flag it and restart the frame on this sample.
              err_q      <= 1'b1;
              sync_out_q <= 1'b1;
              phase_q    <= PH_ONE;
              frame_q    <= frame_q + 32'd1;
            end else begin
              sync_out_q <= (phase_q == '0);
              if (phase_q == '0) frame_q <= frame_q + 32'd1;
              phase_q    <= (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      quadc_clip_lane #(.CNT_W(CNT_W)) u_clip (
        .user_clk (user_clk),
        .reset_n  (reset_n),
        .en       (valid),
        .clr      (clip_clr),
        .sample   (adc_bus[g]),
        .cnt      (clip_q[g])
      );
    end
  endgenerate

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign sync_out  = sync_out_q;
  assign frame_cnt = frame_q;
  assign armed     = (state_q == S_ARMED);
  assign running   = (state_q == S_RUN);
  assign sync_err  = err_q;
  assign clip0     = clip_q[0];
  assign clip1     = clip_q[1];
  assign clip2     = clip_q[2];
  assign clip3     = clip_q[3];
endmodule

// File: tb/tb_quadc_sync_framer.sv
// Directed + random bench for quadc_sync_framer; a sample-index reference model
// predicts every output each cycle.

module tb_quadc_sync_framer;
  localparam int FL = 8;
  localparam int CW = 4;

  logic          user_clk = 1'b0;
  logic          reset_n  = 1'b0;
  logic [7:0]    adc0_data = '0, adc1_data = '0, adc2_data = '0, adc3_data = '0;
  logic          valid = 1'b0, sync = 1'b0, arm = 1'b0;
  logic [31:0]   data_out, frame_cnt;
  logic          valid_out, sync_out, armed, running, sync_err;
  logic [CW-1:0] clip0, clip1, clip2, clip3;

  quadc_sync_framer #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
    .user_clk(user_clk), .reset_n(reset_n),
    .adc0_data(adc0_data), .adc1_data(adc1_data), .adc2_data(adc2_data), .adc3_data(adc3_data),
    .valid(valid), .sync(sync), .arm(arm),
    .data_out(data_out), .valid_out(valid_out), .sync_out(sync_out), .frame_cnt(frame_cnt),
    .armed(armed), .running(running), .sync_err(sync_err),
    .clip0(clip0), .clip1(clip1), .clip2(clip2), .clip3(clip3)
  );

  always #5 user_clk = ~user_clk;

  int n_vec = 0, n_err = 0;

  // Reference model: mode 0/1/2 = idle/armed/running; frame position is the
  // distance in valid samples from the most recent aligning sample.
  int          m_mode, m_vidx, m_origin;
  int          m_clip [4];
  bit          m_armq, m_syncq, m_err, e_so, e_vout;
  logic [31:0] m_frame, e_data;

  function automatic int m_phase();
    return (m_vidx - m_origin) % FL;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_vidx = 0; m_origin = 0; m_armq = 0; m_syncq = 0;
    m_err = 0; e_so = 0; e_vout = 0; m_frame = '0; e_data = '0;
    for (int k = 0; k < 4; k++) m_clip[k] = 0;
  endtask

  task automatic model(input bit v, input bit s, input bit a, input logic [31:0] d);
    bit ae, se, clr;
    int pm;
    logic [7:0] b;
    ae = a && !m_armq;
    se = v && s && !m_syncq;
    pm = m_mode;
    clr = ae && pm != 0;
    e_so = 0;
    if (pm == 0) begin
      if (ae) m_mode = 1;
    end else if (ae) begin
      m_mode = 1; m_frame = '0; m_err = 0;
    end else if (v) begin
      if (pm == 1) begin
        if (se) begin m_mode = 2; m_origin = m_vidx; e_so = 1; end
      end else begin
        if (se && m_phase() != 0) begin m_err = 1; m_origin = m_vidx; end
        e_so = (m_phase() == 0);
      end
    end
    for (int k = 0; k < 4; k++) begin
      b = d[8*k +: 8];
      if (clr) m_clip[k] = 0;
      else if (v && (b == 8'h7F || b == 8'h80) && m_clip[k] < (1 << CW) - 1) m_clip[k]++;
    end
    if (e_so) m_frame = m_frame + 32'd1;
    if (v) begin m_vidx++; m_syncq = s; end
    m_armq = a;
    e_data = d;
    e_vout = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("data_out",  data_out,          e_data);
    chk("valid_out", 32'(valid_out),    32'(e_vout));
    chk("sync_out",  32'(sync_out),     32'(e_so));
    chk("frame_cnt", frame_cnt,         m_frame);
    chk("armed",     32'(armed),        32'(m_mode == 1));
    chk("running",   32'(running),      32'(m_mode == 2));
    chk("sync_err",  32'(sync_err),     32'(m_err));
    chk("clip0",     32'(clip0),        32'(m_clip[0]));
    chk("clip1",     32'(clip1),        32'(m_clip[1]));
    chk("clip2",     32'(clip2),        32'(m_clip[2]));
    chk("clip3",     32'(clip3),        32'(m_clip[3]));
  endtask

  function automatic logic [7:0] rnd8();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 8'h7F;
    if (r == 1) return 8'h80;
    return 8'($urandom);
  endfunction

  function automatic logic [31:0] rndw();
    return {rnd8(), rnd8(), rnd8(), rnd8()};
  endfunction

  task automatic step(input bit v, input bit s, input bit a, input logic [31:0] d);
    @(negedge user_clk);
    valid = v; sync = s; arm = a;
    {adc3_data, adc2_data, adc1_data, adc0_data} = d;
    @(posedge user_clk);
    model(v, s, a, d);
    #1 check_all();
  endtask

  // Reset lands between clock edges to exercise the asynchronous path.
  task automatic mid_reset();
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge user_clk) reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #12 check_all();
    @(negedge user_clk) reset_n = 1'b1;

    // Free-running with no arm: data tracks, no pulses, clips accumulate.
    for (int i = 0; i < 20; i++) step($urandom_range(0, 3) != 0, i[2], 1'b0, rndw());
    mid_reset();
    for (int i = 0; i < 6; i++) step(1'b1, i[0], 1'b0, rndw());

    // Arm, then continuous valid with sync rising at sample 10.
    step(1'b0, 1'b0, 1'b1, rndw());
    for (int i = 0; i < 30; i++) step(1'b1, i >= 10, 1'b1, rndw());
    chk("s2_frames", frame_cnt, 32'd3);
    chk("s2_running", 32'(running), 32'd1);

    // Re-arm and repeat with every third cycle invalid.
    step(1'b0, 1'b0, 1'b0, rndw());
    step(1'b0, 1'b0, 1'b1, rndw());
    for (int i = 0; i < 40; i++) step((i % 3) != 2, i >= 10, 1'b1, rndw());
    chk("s3_frames", frame_cnt, 32'd3);

    // Misaligned sync at phase 5, then an aligned one at phase 0.
    step(1'b1, 1'b0, 1'b1, rndw());
    for (int i = 0; i < 2 * FL && m_phase() != 5; i++) step(1'b1, 1'b0, 1'b1, rndw());
    step(1'b1, 1'b1, 1'b1, rndw());
    chk("s4_err", 32'(sync_err), 32'd1);
    chk("s4_pulse", 32'(sync_out), 32'd1);
    step(1'b1, 1'b0, 1'b1, rndw());
    for (int i = 0; i < 2 * FL && m_phase() != 0; i++) step(1'b1, 1'b0, 1'b1, rndw());
    step(1'b1, 1'b1, 1'b1, rndw());
    chk("s4_aligned_pulse", 32'(sync_out), 32'd1);
    chk("s4_err_sticky", 32'(sync_err), 32'd1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, rndw());

    // Arm edge and sync edge together while running.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0);
    chk("s5_armed", 32'(armed), 32'd1);
    chk("s5_frames", frame_cnt, 32'd0);
    chk("s5_err", 32'(sync_err), 32'd0);
    chk("s5_nopulse", 32'(sync_out), 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0);
    chk("s5_newframe", frame_cnt, 32'd1);

    // Clip saturation on lane 2; lane 1 sits just below full scale.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 32'h0080_7E00);
    chk("s6_clip2", 32'(clip2), 32'd15);
    chk("s6_clip1", 32'(clip1), 32'd0);

    // Random traffic with occasional arms and one mid-run reset.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 29) == 0, rndw());
      if (i == 200) mid_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
